// File: rtl/requant_pkg.sv
// requant_pkg: shared FSM state type and tile/INT8 constants for the requantising writeback block.
package requant_pkg;
  typedef enum logic [1:0] {IDLE, PROC, WRITE, DONE} state_t;
  localparam int TILE_ELEMS = 16;
  localparam int LINE_BYTES = 16;
  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;
endpackage

// File: rtl/requant_lane.sv
// requant_lane: 2-stage per-element datapath (bias add and multiply, then round/shift/zp/saturate).
// Optional REQUANT_RELU_EN clamps the result from below at the zero point.
module requant_lane
  import requant_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_valid,
  input  logic                    i_keep,
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic signed [ACC_W-1:0] i_bias,
  input  logic signed [15:0]      i_mult,
  input  logic        [4:0]       i_shift,
  input  logic signed [7:0]       i_zp,
  output logic                    o_valid,
  output logic                    o_keep,
  output logic        [7:0]       o_byte
);
  localparam int PW = ACC_W + 17;
  localparam int QW = PW + 2;
  localparam logic signed [QW-1:0] Q_MAX = QW'(INT8_MAX);
  localparam logic signed [QW-1:0] Q_MIN = QW'(INT8_MIN);

  logic signed [ACC_W:0] w_v;
  logic signed [PW-1:0]  w_p;
  logic signed [PW-1:0]  r_p;
  logic                  r_valid1;
  logic                  r_keep1;
  logic signed [QW-1:0]  w_rnd;
  logic signed [QW-1:0]  w_pr;
  logic signed [QW-1:0]  w_r;
  logic signed [QW-1:0]  w_q;
  logic signed [7:0]     w_sat;
  logic signed [7:0]     w_out;

  assign w_v = (ACC_W+1)'(i_acc) + (ACC_W+1)'(i_bias);
  assign w_p = PW'(w_v) * PW'(i_mult);

  // Round half up before the arithmetic shift; two guard bits keep the sum exact.
  assign w_rnd = (i_shift == 5'd0) ? '0 : QW'(1) << (i_shift - 5'd1);
  assign w_pr  = QW'(r_p) + w_rnd;
  assign w_r   = w_pr >>> i_shift;
  assign w_q   = w_r + QW'(i_zp);
  assign w_sat = (w_q > Q_MAX) ? 8'(INT8_MAX) : (w_q < Q_MIN) ? 8'(INT8_MIN) : w_q[7:0];

`ifdef REQUANT_RELU_EN
  assign w_out = (w_sat < i_zp) ? i_zp : w_sat;
`else
  assign w_out = w_sat;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid1 <= 1'b0;
      r_keep1  <= 1'b0;
      r_p      <= '0;
      o_valid  <= 1'b0;
      o_keep   <= 1'b0;
      o_byte   <= '0;
    end else begin
      r_valid1 <= i_valid;
      r_keep1  <= i_keep;
      r_p      <= w_p;
      o_valid  <= r_valid1;
      o_keep   <= r_keep1;
      o_byte   <= r_keep1 ? w_out : 8'h00;
    end
  end
endmodule

// File: rtl/requant_writeback.sv
// requant_writeback: requantises a 4x4 accumulator tile to INT8 and writes it as one 16-byte masked line.
// Define REQUANT_RELU_EN to enable the ReLU clamp at the zero point inside requant_lane.
module requant_writeback
  import requant_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [TILE_ELEMS*ACC_W-1:0]  acc_in,
  input  logic [4*ACC_W-1:0]           bias_in,
  input  logic [2:0]                   m_dim,
  input  logic [2:0]                   n_dim,
  input  logic signed [15:0]           mult,
  input  logic [4:0]                   shift,
  input  logic signed [7:0]            zp,
  input  logic [ADDR_W-1:0]            dst_addr,
  output logic [ADDR_W-1:0]            mem_waddr,
  output logic [8*LINE_BYTES-1:0]      mem_wdata,
  output logic [LINE_BYTES-1:0]        mem_wmask,
  output logic                         mem_wvalid,
  input  logic                         mem_wready,
  output logic                         busy,
  output logic                         done
);
  state_t r_state, w_next;
  logic [TILE_ELEMS*ACC_W-1:0] r_acc;
  logic [4*ACC_W-1:0]          r_bias;
  logic [2:0]                  r_m, r_n;
  logic signed [15:0]          r_mult;
  logic [4:0]                  r_shift;
  logic signed [7:0]           r_zp;
  logic [3:0]                  r_k, r_k1, r_k2;
  logic                        r_iss;
  logic                        w_start, w_issue, w_keep, w_last;
  logic                        w_lane_valid, w_lane_keep;
  logic [7:0]                  w_lane_byte;
  logic [1:0]                  w_i, w_j;

  assign w_start = (r_state == IDLE) && start;
  assign w_issue = (r_state == PROC) && r_iss;
  assign w_i     = r_k[3:2];
  assign w_j     = r_k[1:0];
  assign w_keep  = ({1'b0, w_i} < r_m) && ({1'b0, w_j} < r_n);
  assign w_last  = w_lane_valid && (r_k2 == 4'd15);

  requant_lane #(.ACC_W(ACC_W)) u_lane (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_issue),
    .i_keep  (w_keep),
    .i_acc   (r_acc[r_k*ACC_W +: ACC_W]),
    .i_bias  (r_bias[w_j*ACC_W +: ACC_W]),
    .i_mult  (r_mult),
    .i_shift (r_shift),
    .i_zp    (r_zp),
    .o_valid (w_lane_valid),
    .o_keep  (w_lane_keep),
    .o_byte  (w_lane_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? PROC : IDLE;
      PROC:    w_next = w_last ? WRITE : PROC;
      WRITE:   w_next = mem_wready ? DONE : WRITE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      r_bias    <= '0;
      r_m       <= '0;
      r_n       <= '0;
      r_mult    <= '0;
      r_shift   <= '0;
      r_zp      <= '0;
      r_k       <= '0;
      r_k1      <= '0;
      r_k2      <= '0;
      r_iss     <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (w_start) begin
      r_acc     <= acc_in;
      r_bias    <= bias_in;
      r_m       <= m_dim;
      r_n       <= n_dim;
      r_mult    <= mult;
      r_shift   <= shift;
      r_zp      <= zp;
      r_k       <= '0;
      r_iss     <= 1'b1;
      mem_waddr <= dst_addr & ~ADDR_W'(15);
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (r_state == PROC) begin
      r_k  <= r_iss ? r_k + 4'd1 : r_k;
      r_iss <= r_iss && (r_k != 4'd15);
      r_k1 <= r_k;
      r_k2 <= r_k1;
      if (w_lane_valid) begin
        mem_wdata[8*r_k2 +: 8] <= w_lane_byte;
        mem_wmask[r_k2]        <= w_lane_keep;
      end
    end
  end

  assign mem_wvalid = (r_state == WRITE);
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
endmodule
